// File: rtl/farbborg_pkg.sv
// Shared definitions for the frame_loader byte-stream protocol.
package farbborg_pkg;

  localparam logic [7:0] ESC         = 8'h23;
  localparam int         FRAME_BYTES = 1536;

  localparam logic [7:0] CMD_LIT  = 8'h00;
  localparam logic [7:0] CMD_SOF  = 8'h01;
  localparam logic [7:0] CMD_SEEK = 8'h02;
  localparam logic [7:0] CMD_SUM  = 8'h03;

  typedef enum logic [2:0] {
    ST_DATA,
    ST_ESC_SEEN,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_SUM
  } state_t;

endpackage

// File: rtl/frame_loader.sv
// frame_loader: unescapes a UART byte stream into frame-buffer writes.
// Optional checksum command and sum_err output: define LOADER_CHECKSUM_EN.
module frame_loader #(
  parameter int         ADDR_W      = 11,
  parameter int         FRAME_BYTES = farbborg_pkg::FRAME_BYTES,
  parameter logic [7:0] ESC         = farbborg_pkg::ESC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        din,
  output logic              we,
  output logic              frame_done,
  output logic              proto_err,
  output logic              sum_err
);
  import farbborg_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BYTES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              we_q, we_d;
  logic              frame_done_q, frame_done_d;
  logic              proto_err_q, proto_err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              sum_err_q, sum_err_d;
`endif

  logic              wr;
  logic [7:0]        wr_byte;
  logic [15:0]       seek_full;
  logic [ADDR_W-1:0] seek;

  // Seek target is the 16-bit {hi, lo} pair truncated to the address width.
  assign seek_full = {hi_q, rx_data};
  assign seek      = ADDR_W'(seek_full);

  // Protocol decode, pointer/sum update and registered write port.
  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    din_d        = din_q;
    we_d         = 1'b0;
    frame_done_d = 1'b0;
    proto_err_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    sum_err_d    = 1'b0;
`endif
    wr           = 1'b0;
    wr_byte      = rx_data;
    if (rx_valid) begin
      case (state_q)
        ST_DATA: begin
          if (rx_data == ESC) state_d = ST_ESC_SEEN;
          else                wr      = 1'b1;
        end
        ST_ESC_SEEN: begin
          state_d = ST_DATA;
          case (rx_data)
            CMD_LIT: begin
              wr      = 1'b1;
              wr_byte = ESC;
            end
            CMD_SOF: begin
              wp_d = '0;
`ifdef LOADER_CHECKSUM_EN
              sum_d = '0;
`endif
            end
            CMD_SEEK: state_d = ST_ADDR_HI;
`ifdef LOADER_CHECKSUM_EN
            CMD_SUM:  state_d = ST_SUM;
`endif
            default:  proto_err_d = 1'b1;
          endcase
        end
        ST_ADDR_HI: begin
          hi_d    = rx_data;
          state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          if (seek <= LAST) wp_d        = seek;
          else              proto_err_d = 1'b1;
          state_d = ST_DATA;
        end
`ifdef LOADER_CHECKSUM_EN
        ST_SUM: begin
          sum_err_d = (rx_data != sum_q);
          sum_d     = '0;
          state_d   = ST_DATA;
        end
`endif
        default: state_d = ST_DATA;
      endcase
    end
    // Data and literal-escape writes share one path: write at wp, then advance/wrap.
    if (wr) begin
      we_d   = 1'b1;
      addr_d = wp_q;
      din_d  = wr_byte;
`ifdef LOADER_CHECKSUM_EN
      sum_d  = sum_q + wr_byte;
`endif
      if (wp_q == LAST) begin
        wp_d         = '0;
        frame_done_d = 1'b1;
      end else begin
        wp_d = wp_q + ADDR_W'(1);
      end
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_DATA;
      wp_q         <= '0;
      hi_q         <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
      sum_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      hi_q         <= hi_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      we_q         <= we_d;
      frame_done_q <= frame_done_d;
      proto_err_q  <= proto_err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      sum_err_q    <= sum_err_d;
`endif
    end
  end

  assign addr       = addr_q;
  assign din        = din_q;
  assign we         = we_q;
  assign frame_done = frame_done_q;
  assign proto_err  = proto_err_q;
`ifdef LOADER_CHECKSUM_EN
  assign sum_err    = sum_err_q;
`else
  assign sum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: directed protocol cases plus randomized streams,
// checked every cycle against a byte-level model of the protocol.
module tb_frame_loader;
  localparam int         AW   = 11;
  localparam int         FB   = 1536;
  localparam logic [7:0] ESCB = 8'h23;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] addr;
  logic [7:0]    din;
  logic          we, frame_done, proto_err, sum_err;

  frame_loader #(.ADDR_W(AW), .FRAME_BYTES(FB), .ESC(ESCB)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr(addr), .din(din), .we(we), .frame_done(frame_done),
    .proto_err(proto_err), .sum_err(sum_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  // Model: mode 0 data, 1 after escape, 2 expect hi, 3 expect lo, 4 expect checksum.
  int       m_mode = 0;
  int       m_wp   = 0;
  int       m_hi   = 0;
  int       m_sum  = 0;
  // Expected outputs for the current cycle (exp) and for the next cycle (nxt).
  int e_addr = 0, e_din = 0; bit e_we = 0, e_fd = 0, e_pe = 0, e_se = 0;
  int n_addr = 0, n_din = 0; bit n_we = 0, n_fd = 0, n_pe = 0, n_se = 0;

  task automatic m_write(input int b);
    n_we = 1; n_addr = m_wp; n_din = b;
    m_sum = (m_sum + b) % 256;
    if (m_wp == FB - 1) begin n_fd = 1; m_wp = 0; end
    else m_wp = m_wp + 1;
  endtask

  task automatic m_byte(input int b);
    int seek;
    case (m_mode)
      0: if (b == ESCB) m_mode = 1; else m_write(b);
      1: begin
        m_mode = 0;
        if (b == 0) m_write(ESCB);
        else if (b == 1) begin m_wp = 0; m_sum = 0; end
        else if (b == 2) m_mode = 2;
`ifdef LOADER_CHECKSUM_EN
        else if (b == 3) m_mode = 4;
`endif
        else n_pe = 1;
      end
      2: begin m_hi = b; m_mode = 3; end
      3: begin
        seek = (m_hi * 256 + b) % (1 << AW);
        if (seek < FB) m_wp = seek; else n_pe = 1;
        m_mode = 0;
      end
      default: begin
        if (b != m_sum) n_se = 1;
        m_sum = 0; m_mode = 0;
      end
    endcase
  endtask

  task automatic m_reset();
    m_mode = 0; m_wp = 0; m_sum = 0; m_hi = 0;
    e_addr = 0; e_din = 0; e_we = 0; e_fd = 0; e_pe = 0; e_se = 0;
    n_addr = 0; n_din = 0; n_we = 0; n_fd = 0; n_pe = 0; n_se = 0;
  endtask

  // Advance the model's registered view at each clock edge.
  always @(posedge clk) begin
    if (reset) begin
      e_addr = n_addr; e_din = n_din; e_we = n_we;
      e_fd = n_fd; e_pe = n_pe; e_se = n_se;
      n_we = 0; n_fd = 0; n_pe = 0; n_se = 0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (int'(addr) != e_addr || int'(din) != e_din || we != e_we ||
          frame_done != e_fd || proto_err != e_pe || sum_err != e_se) begin
        errors++;
        $display("FAIL cycle t=%0t got addr=%0d din=%02h we=%b fd=%b pe=%b se=%b want addr=%0d din=%02h we=%b fd=%b pe=%b se=%b",
                 $time, addr, din, we, frame_done, proto_err, sum_err,
                 e_addr, e_din, e_we, e_fd, e_pe, e_se);
      end
    end
  end

  task automatic tick(input bit v, input int b);
    @(posedge clk); #1;
    rx_valid = v;
    rx_data  = 8'(b);
    if (v) m_byte(b);
  endtask

  task automatic send(input int b);
    tick(1, b);
  endtask

  task automatic idle();
    tick(0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rx_valid = 0;
    reset = 0;
    m_reset();
    @(posedge clk); #1;
    reset = 1;
  endtask

  // Literal expectation taken straight from hand-worked protocol cases.
  task automatic lit(input string name, input bit w, input int a, input int d,
                     input bit fd, input bit pe, input bit se);
    checks++;
    if (we != w || int'(addr) != a || int'(din) != d || frame_done != fd ||
        proto_err != pe || sum_err != se) begin
      errors++;
      $display("FAIL %s got we=%b addr=%0d din=%02h fd=%b pe=%b se=%b want we=%b addr=%0d din=%02h fd=%b pe=%b se=%b",
               name, we, addr, din, frame_done, proto_err, sum_err, w, a, d, fd, pe, se);
    end
  endtask

  int r, b;

  initial begin
    #2 reset = 0;
    m_reset();
    #1 started = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    lit("reset_state", 0, 0, 0, 0, 0, 0);

    // Two data bytes, one cycle latency each.
    send(8'h11); send(8'h22); lit("first_write", 1, 0, 8'h11, 0, 0, 0);
    idle();                   lit("second_write", 1, 1, 8'h22, 0, 0, 0);
    idle();                   lit("hold", 0, 1, 8'h22, 0, 0, 0);

    // Full frame from address 0 then wrap.
    send(8'h23); send(8'h01);
    for (int i = 0; i < FB; i++) begin
      b = $urandom_range(0, 255);
      if (b == ESCB) b = 8'h00;
      send(b);
    end
    idle(); lit("frame_last", 1, FB - 1, e_din, 1, 0, 0);
    send(8'h5A); idle(); lit("wrap_to_0", 1, 0, 8'h5A, 0, 0, 0);

    // Literal escape at wp=1, then frame start.
    send(8'h23); send(8'h00); idle(); lit("literal_esc", 1, 1, 8'h23, 0, 0, 0);
    send(8'h23); send(8'h01); send(8'h55); idle(); lit("sof_write", 1, 0, 8'h55, 0, 0, 0);

    // Seeks and unknown code.
    send(8'h23); send(8'h02); send(8'h01); send(8'h00); send(8'h77);
    idle(); lit("seek_256", 1, 256, 8'h77, 0, 0, 0);
    send(8'h23); send(8'h02); send(8'h06); send(8'h00);
    idle(); lit("seek_oor", 0, 256, 8'h77, 0, 1, 0);
    send(8'h88); idle(); lit("wp_kept", 1, 257, 8'h88, 0, 0, 0);
    send(8'h23); send(8'h07); idle(); lit("bad_code", 0, 257, 8'h88, 0, 1, 0);
    send(8'h23); send(8'h02); send(8'h08); send(8'h05); send(8'h66);
    idle(); lit("seek_trunc", 1, 5, 8'h66, 0, 0, 0);

    // Checksum command.
    send(8'h23); send(8'h01); send(8'h01); send(8'h02); send(8'h03);
    send(8'h23); send(8'h03); send(8'h06); idle();
`ifdef LOADER_CHECKSUM_EN
    lit("sum_ok", 0, 2, 8'h03, 0, 0, 0);
    send(8'h23); send(8'h01); send(8'h01); send(8'h02); send(8'h03);
    send(8'h23); send(8'h03); send(8'h07); idle();
    lit("sum_bad", 0, 2, 8'h03, 0, 0, 1);
`else
    lit("sum_code_unknown", 1, 3, 8'h06, 0, 0, 0);
`endif

    // Reset in the middle of a seek.
    send(8'h23); send(8'h02); send(8'h01);
    @(posedge clk); #1;
    rx_valid = 0;
    reset = 0;
    m_reset();
    #1 lit("reset_mid_seek", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 reset = 1;
    send(8'h09); idle(); lit("after_reset", 1, 0, 8'h09, 0, 0, 0);

    // Randomized protocol traffic.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 16) send(ESCB);
      else if (r < 26) begin
        send(ESCB); send(8'h02);
        send((r < 22) ? $urandom_range(0, 9) : $urandom_range(0, 255));
        send($urandom_range(0, 255));
      end else if (r < 40) send($urandom_range(0, 7));
      else if (r < 46) begin
        send(ESCB); send(8'h03);
        send((r < 43) ? m_sum : $urandom_range(0, 255));
      end else if (r < 60) idle();
      else if (r < 61) do_reset();
      else send($urandom_range(0, 255));
    end
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
# frame_loader

Upstream feeder for the `pwm` frame buffer: converts a received byte stream into single-cycle frame-buffer writes on `addr`/`din`/`we`. The input is an escaped stream of bytes from the UART receiver. The block manages the write address itself: it auto-increments, wraps at the end of the frame, accepts explicit seeks, and flags protocol errors.

## Interface
- `ADDR_W`, 11: frame-buffer address width; matches `pwm` `addr`.
- `FRAME_BYTES`, 1536: bytes per frame (8x8x8 voxels x RGB); the highest valid address is `FRAME_BYTES-1`.
- `ESC`, 8'h23: escape byte value.
- `clk`  in  1: system clock; shared with the `pwm` write port.
- `reset`  in  1: asynchronous, active-low reset.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: one-cycle strobe, `rx_data` valid; at most one per cycle.
- `addr`  out  ADDR_W: frame-buffer write address.
- `din`  out  8: frame-buffer write data.
- `we`  out  1: write strobe, one cycle per data byte.
- `frame_done`  out  1: one-cycle pulse when the write at `FRAME_BYTES-1` occurs.
- `proto_err`  out  1: one-cycle pulse on an unknown escape code or an out-of-range seek.
- `sum_err`  out  1: one-cycle pulse on checksum mismatch; present only with `LOADER_CHECKSUM_EN`, otherwise tied 0.

## Operation
- **States:** DATA (reset state), ESC_SEEN, ADDR_HI, ADDR_LO, plus SUM (only with the macro).
- **DATA:**
  - Byte != `ESC`: write it at the write pointer `wp`, then `wp` = `wp`+1.
  - If the written address was `FRAME_BYTES-1`: `wp` = 0 and `frame_done` pulses.
  - Byte == `ESC`: go to ESC_SEEN.
- **ESC_SEEN, next byte:**
  - 8'h00: literal `ESC` written as data.
  - 8'h01: frame start; `wp` = 0, running sum = 0.
  - 8'h02: go to ADDR_HI.
  - 8'h03: go to SUM (with the macro).
  - Any other value: `proto_err`, no write.
  - Every code except 8'h02 and 8'h03 returns to DATA.
- **ADDR_HI:** latch the byte into a hi register; go to ADDR_LO.
- **ADDR_LO:**
  - seek = {hi, lo}, truncated to `ADDR_W` bits.
  - seek < `FRAME_BYTES`: `wp` = seek.
  - Otherwise: `proto_err` and `wp` unchanged.
  - Return to DATA.
- **Running sum:** 8-bit modulo-256 sum of every byte written, including literal escapes. Command bytes are not summed.
- **Idle cycles:** when `rx_valid` = 0, state, `wp` and sum hold; the time between bytes is unlimited.
- **Reset mid-sequence:** an escape or seek in progress is discarded. After reset the block is in DATA with `wp` = 0.

## Timing
- **Reset values:** `addr` = 0, `din` = 0, `we` = 0, `frame_done` = 0, `proto_err` = 0, `sum_err` = 0, state = DATA, `wp` = 0, sum = 0.
- **Write latency:** if `rx_valid` is high in cycle N, `we`, `addr` and `din` are registered and valid in cycle N+1.
  - `addr` carries the pre-increment pointer.
  - `we` is high for exactly one cycle.
- **Hold:** `addr`/`din` keep their last value while `we` = 0.
- **Pulse alignment:** `frame_done` shares the cycle of the final `we`. `proto_err` and `sum_err` occur in the cycle after the offending byte.
- **Throughput:** back-to-back `rx_valid` gives back-to-back writes. There is no backpressure; `pwm` accepts a write every cycle.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - Escape code 8'h03 enters SUM.
  - The next byte is compared with the running sum; a mismatch pulses `sum_err`.
  - The sum is then cleared and the state returns to DATA.
- **Not defined:**
  - 8'h03 is an unknown code and pulses `proto_err`.
  - The SUM state and sum register are absent; `sum_err` is constant 0.

## Structure
- **Shared package `farbborg_pkg`:** the state encoding enum, `ESC` and the command code constants (`CMD_LIT`=0, `CMD_SOF`=1, `CMD_SEEK`=2, `CMD_SUM`=3), and the default `FRAME_BYTES`.
- **No sub-module:** a single flat FSM plus pointer and sum registers.

## Test plan
1. Bytes 8'h11, 8'h22 after reset -> `we` pulses with `addr` 0/`din` 8'h11, then `addr` 1/`din` 8'h22, each one cycle after its `rx_valid`.
2. 1536 data bytes -> last write at `addr` 1535 with `frame_done` in the same cycle; the next byte is written at `addr` 0.
3. Stream 23 00, then 23 01, then 8'h55 -> literal 8'h23 written at the current `wp`; the 8'h55 is then written at `addr` 0.
4. Seek 23 02 01 00, then 8'h77 -> write at `addr` 256. Seek 23 02 06 00 -> `proto_err` and `wp` unchanged. Code 23 07 -> `proto_err` and no write.
5. With the macro: 23 01, 01 02 03, 23 03 06 -> no `sum_err`. Repeat with checksum 8'h07 -> `sum_err` pulses. Without the macro, 23 03 -> `proto_err`.
6. Assert `reset` low after 23 02 01 -> all outputs 0. After release, 8'h09 is written at `addr` 0.
